// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX pipeline register with stall hold, flush bubble and saturating event counters
module id_ex_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              RegWrite_i,
    input  logic              MemtoReg_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [1:0]        ALUOp_i,
    input  logic              ALUSrc_i,
    input  logic [DATA_W-1:0] PC_i,
    input  logic [DATA_W-1:0] RS1data_i,
    input  logic [DATA_W-1:0] RS2data_i,
    input  logic [DATA_W-1:0] Imm_i,
    input  logic [9:0]        funct_i,
    input  logic [4:0]        RS1addr_i,
    input  logic [4:0]        RS2addr_i,
    input  logic [4:0]        RDaddr_i,
    output logic              RegWrite_o,
    output logic              MemtoReg_o,
    output logic              MemRead_o,
    output logic              MemWrite_o,
    output logic [1:0]        ALUOp_o,
    output logic              ALUSrc_o,
    output logic [DATA_W-1:0] PC_o,
    output logic [DATA_W-1:0] RS1data_o,
    output logic [DATA_W-1:0] RS2data_o,
    output logic [DATA_W-1:0] Imm_o,
    output logic [9:0]        funct_o,
    output logic [4:0]        RS1addr_o,
    output logic [4:0]        RS2addr_o,
    output logic [4:0]        RDaddr_o,
    output logic              valid_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);
    // Stage contents: reset and flush both load an all-zero bubble, stall holds, else load from ID
    always_ff @(posedge clk_i) begin
        if (!rst_i || flush_i) begin
            RegWrite_o <= 1'b0;
            MemtoReg_o <= 1'b0;
            MemRead_o  <= 1'b0;
            MemWrite_o <= 1'b0;
            ALUOp_o    <= 2'b00;
            ALUSrc_o   <= 1'b0;
            PC_o       <= '0;
            RS1data_o  <= '0;
            RS2data_o  <= '0;
            Imm_o      <= '0;
            funct_o    <= '0;
            RS1addr_o  <= '0;
            RS2addr_o  <= '0;
            RDaddr_o   <= '0;
            valid_o    <= 1'b0;
        end else if (!stall_i) begin
            RegWrite_o <= RegWrite_i;
            MemtoReg_o <= MemtoReg_i;
            MemRead_o  <= MemRead_i;
            MemWrite_o <= MemWrite_i;
            ALUOp_o    <= ALUOp_i;
            ALUSrc_o   <= ALUSrc_i;
            PC_o       <= PC_i;
            RS1data_o  <= RS1data_i;
            RS2data_o  <= RS2data_i;
            Imm_o      <= Imm_i;
            funct_o    <= funct_i;
            RS1addr_o  <= RS1addr_i;
            RS2addr_o  <= RS2addr_i;
            RDaddr_o   <= RDaddr_i;
            valid_o    <= 1'b1;
        end
    end

    // Saturating stall counter: a flush in the same cycle is a bubble, not a stall
    always_ff @(posedge clk_i) begin
        if (!rst_i)
            stall_cnt_o <= '0;
        else if (stall_i && !flush_i && stall_cnt_o != '1)
            stall_cnt_o <= stall_cnt_o + 1'b1;
    end

    // Saturating bubble counter
    always_ff @(posedge clk_i) begin
        if (!rst_i)
            bubble_cnt_o <= '0;
        else if (flush_i && bubble_cnt_o != '1)
            bubble_cnt_o <= bubble_cnt_o + 1'b1;
    end
endmodule
